uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd50000: cycles allowed in WAIT_BUSY or WAIT_DONE before abort; used only when UART_TX_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  per-requester transmit request, level; held until the matching ack.
REQ-005 req_data  input  32  packed bytes; requester i occupies bits [8i+7:8i]; stable while req[i] is high.
REQ-006 ack  output  4  one-cycle pulse; ack[i] means requester i's byte was accepted by the transmitter.
REQ-007 Tx_DATA  output  8  byte presented to the UART transmitter.
REQ-008 Tx_WR  output  1  one-cycle write strobe to the transmitter.
REQ-009 Tx_BUSY  input  1  transmitter busy flag; high from accept until the stop bit ends.
REQ-010 grant  output  2  index of the requester currently being served.
REQ-011 arb_busy  output  1  high in every state except IDLE.
REQ-012 tx_timeout  output  1  one-cycle pulse on timeout abort.

Function
REQ-013 FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-014 IDLE: if any req bit is high and Tx_BUSY=0, select the winner, latch Tx_DATA and grant from it, and go to LOAD; otherwise stay in IDLE.
REQ-015 Arbitration: round-robin; search starts at last_grant+1 mod 4; the first high req wins.
REQ-016 If Tx_BUSY=1 in IDLE, no grant is issued; the FSM waits in IDLE.
REQ-017 LOAD: Tx_WR=1 for exactly this one cycle; Tx_DATA is held; next state is WAIT_BUSY.
REQ-018 Latency: req sampled in IDLE at edge k; Tx_WR is high between edges k+1 and k+2.
REQ-019 WAIT_BUSY: on Tx_BUSY=1, pulse ack[grant] for one cycle and go to WAIT_DONE.
REQ-020 WAIT_DONE: on Tx_BUSY=0, set last_grant=grant and go to IDLE; a new grant is possible on the next edge.
REQ-021 A requester that drops req after LOAD still completes the transfer and still receives ack.
REQ-022 Tx_DATA and grant are constant from LOAD until the return to IDLE.
REQ-023 ack is one-hot or zero; at most one ack is issued per Tx_WR.
REQ-024 With all four req bits held high, the service order is 0,1,2,3,0,...
REQ-025 Simultaneous events: a req change in the same cycle as Tx_BUSY falling is seen only in IDLE on the following edge.

Reset
REQ-026 While reset is high, all of the following hold:
- FSM state = IDLE.
- ack, Tx_WR, tx_timeout, arb_busy = 0.
- Tx_DATA = 8'h00; grant = 2'd0.
- last_grant = 2'd3, so requester 0 has first priority.
- Timeout counter = 0.
REQ-027 Reset mid-transfer aborts immediately with no ack; the transmitter's own state is not affected.

Configuration
REQ-028 Macro UART_TX_ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT_BUSY and counts every cycle in WAIT_BUSY/WAIT_DONE.
- On reaching TIMEOUT_CYCLES: tx_timeout pulses, no ack is issued, last_grant=grant, and the FSM goes to IDLE.
- Not defined: there is no counter, the FSM waits indefinitely, and tx_timeout is tied to 0.

Verification
REQ-029 Single request: req=4'b0100, req_data[23:16]=8'hA5; Tx_BUSY rises 2 cycles after Tx_WR and stays high 160 cycles -> Tx_DATA=8'hA5, one Tx_WR pulse, grant=2, ack=4'b0100 once, arb_busy low after Tx_BUSY falls.
REQ-030 Contention: req=4'b1111, bytes 11/22/33/44 -> Tx_WR order 8'h11,8'h22,8'h33,8'h44, then 8'h11 again.
REQ-031 Blocked start: Tx_BUSY=1 at reset release, req=4'b0001 -> no Tx_WR until Tx_BUSY=0, then Tx_WR after one cycle.
REQ-032 Reset mid-transfer: assert reset in WAIT_DONE -> all outputs 0 the same cycle, no ack; after release, req=4'b1000 is served with grant=3.
REQ-033 Timeout (macro defined, TIMEOUT_CYCLES=100): Tx_BUSY never rises -> tx_timeout pulse 100 cycles after LOAD, ack stays 4'b0000, then IDLE.
REQ-034 Timeout (macro undefined): the same stimulus held for 10000 cycles -> FSM stays in WAIT_BUSY, tx_timeout=0 throughout.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter between four requesters.
// A winner's byte is latched in IDLE, written with a one-cycle Tx_WR strobe,
// and acknowledged once the transmitter reports busy. The arbiter then waits
// for the transmitter to finish before it arbitrates again.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to enable a watchdog that
// aborts a transfer stuck in WAIT_BUSY/WAIT_DONE after TIMEOUT_CYCLES cycles.
// Without the macro there is no counter and tx_timeout is tied low.
module uart_tx_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [7:0]  Tx_DATA,
  output logic        Tx_WR,
  input  logic        Tx_BUSY,
  output logic [1:0]  grant,
  output logic        arb_busy,
  output logic        tx_timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_wr_q, tx_wr_d;
  logic [3:0]  ack_q, ack_d;
  logic [1:0]  winner_s;
  logic        timeout_hit_s;

  // Round-robin pick: scan upward starting one past the last served index.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = 2'd0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + i[1:0];
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        win   = win;
      end
    end
    return win;
  endfunction

  assign winner_s = rr_pick(req, last_grant_q);

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tx_timeout_q, tx_timeout_d;

  // Watchdog count: cleared while loading, advances in both wait states.
  always_comb begin
    tmo_cnt_d     = tmo_cnt_q;
    timeout_hit_s = 1'b0;
    if (state_q == LOAD) begin
      tmo_cnt_d = 16'd0;
    end else if ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) begin
      tmo_cnt_d     = tmo_cnt_q + 16'd1;
      timeout_hit_s = (tmo_cnt_q == (TIMEOUT_CYCLES - 16'd1));
    end else begin
      tmo_cnt_d = 16'd0;
    end
    tx_timeout_d = timeout_hit_s;
  end

  // Watchdog registers, including the registered timeout pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q    <= 16'd0;
      tx_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q    <= tmo_cnt_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  assign tx_timeout = tx_timeout_q;
`else
  logic unused_timeout_s;

  assign timeout_hit_s    = 1'b0;
  assign tx_timeout       = 1'b0;
  assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tx_data_d    = tx_data_q;
    tx_wr_d      = 1'b0;
    ack_d        = 4'b0000;
    case (state_q)
      IDLE: begin
        if ((req != 4'b0000) && !Tx_BUSY) begin
          grant_d   = winner_s;
          tx_data_d = req_data[{winner_s, 3'b000} +: 8];
          state_d   = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // Strobe is registered, so it appears during the first WAIT_BUSY cycle.
        tx_wr_d = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (timeout_hit_s) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (Tx_BUSY) begin
          ack_d   = 4'b0001 << grant_q;
          state_d = WAIT_DONE;
        end else begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (timeout_hit_s) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (!Tx_BUSY) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; reset aborts any transfer at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      tx_data_q    <= 8'h00;
      tx_wr_q      <= 1'b0;
      ack_q        <= 4'b0000;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
      tx_wr_q      <= tx_wr_d;
      ack_q        <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign Tx_DATA  = tx_data_q;
  assign Tx_WR    = tx_wr_q;
  assign grant    = grant_q;
  assign arb_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus a randomized run
// checked against a timeline-level reference model of arbiter and transmitter.
module tb_uart_tx_arbiter;

  localparam int RN = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic        Tx_BUSY = 1'b0;
  logic [3:0]  ack;
  logic [7:0]  Tx_DATA;
  logic        Tx_WR;
  logic [1:0]  grant;
  logic        arb_busy;
  logic        tx_timeout;

  int tests_run = 0;
  int tests_failed = 0;

  int   mon_wr_cnt, mon_ack_cnt, mon_tmo_cnt;
  logic [3:0] mon_ack_or;
  bit   drop_on_ack = 1'b1;

  // random-phase model state
  logic [3:0] req_hist [0:RN];
  logic       busy_hist [0:RN];
  logic [1:0] win, last_m;
  logic [7:0] exp_byte;
  logic [3:0] waiting;
  logic       exp_wr;
  bit         in_xfer;
  int         rise_at, hold, ack_due, ready, xfers;

  logic [7:0] exp_bytes [5];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16'd100)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .Tx_DATA    (Tx_DATA),
    .Tx_WR      (Tx_WR),
    .Tx_BUSY    (Tx_BUSY),
    .grant      (grant),
    .arb_busy   (arb_busy),
    .tx_timeout (tx_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clear_mon;
    mon_wr_cnt  = 0;
    mon_ack_cnt = 0;
    mon_tmo_cnt = 0;
    mon_ack_or  = 4'b0000;
  endtask

  // Advance one cycle and tally strobes; requesters drop req when acked.
  task automatic tick_mon;
    tick;
    if (Tx_WR === 1'b1) mon_wr_cnt++;
    if (tx_timeout === 1'b1) mon_tmo_cnt++;
    if (ack !== 4'b0000) begin
      mon_ack_cnt++;
      mon_ack_or = mon_ack_or | ack;
      check_eq("ack_onehot", $countones(ack), 1);
      if (drop_on_ack) req = req & ~ack;
    end
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    req     = 4'b0000;
    Tx_BUSY = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic wait_wr(input string tag);
    int k;
    k = 0;
    while (Tx_WR !== 1'b1 && k < 20) begin
      tick_mon;
      k++;
    end
    check_eq(tag, Tx_WR, 1);
  endtask

  // Transmitter behaviour: busy rises after delay cycles, stays for hold.
  task automatic transmit(input int delay, input int hold_c);
    repeat (delay) tick_mon;
    Tx_BUSY = 1'b1;
    repeat (hold_c) tick_mon;
    Tx_BUSY = 1'b0;
    tick_mon;
  endtask

  function automatic logic [1:0] rr_model(input logic [3:0] r, input logic [1:0] last);
    for (int j = 1; j <= 4; j++) begin
      int idx;
      idx = (int'(last) + j) % 4;
      if (r[idx]) return idx[1:0];
    end
    return 2'd0;
  endfunction

  initial begin
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    // Reset state
    tick;
    tick;
    check_eq("rst_ack", ack, 0);
    check_eq("rst_wr", Tx_WR, 0);
    check_eq("rst_data", Tx_DATA, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", arb_busy, 0);
    check_eq("rst_tmo", tx_timeout, 0);

    // Single request from requester 2
    do_reset;
    clear_mon;
    drop_on_ack = 1'b1;
    req_data = 32'h00A5_0000;
    req = 4'b0100;
    tick_mon;
    check_eq("single_wr_early", Tx_WR, 0);
    check_eq("single_load_busy", arb_busy, 1);
    tick_mon;
    check_eq("single_wr", Tx_WR, 1);
    check_eq("single_data", Tx_DATA, 8'hA5);
    check_eq("single_grant", grant, 2);
    transmit(2, 160);
    check_eq("single_idle", arb_busy, 0);
    check_eq("single_wr_cnt", mon_wr_cnt, 1);
    check_eq("single_ack_cnt", mon_ack_cnt, 1);
    check_eq("single_ack", mon_ack_or, 4'b0100);

    // Contention with all four held high
    do_reset;
    clear_mon;
    drop_on_ack = 1'b0;
    req_data = 32'h4433_2211;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_wr("cont_wr");
      check_eq("cont_data", Tx_DATA, exp_bytes[t]);
      check_eq("cont_grant", grant, t % 4);
      transmit(1, 4);
    end
    req = 4'b0000;
    drop_on_ack = 1'b1;
    check_eq("cont_ack_cnt", mon_ack_cnt, 5);
    check_eq("cont_wr_cnt", mon_wr_cnt, 5);

    // Blocked start: transmitter busy at reset release
    reset = 1'b1;
    Tx_BUSY = 1'b1;
    req_data = 32'h0000_005A;
    req = 4'b0001;
    tick;
    tick;
    reset = 1'b0;
    clear_mon;
    repeat (10) tick_mon;
    check_eq("blk_no_wr", mon_wr_cnt, 0);
    check_eq("blk_idle", arb_busy, 0);
    Tx_BUSY = 1'b0;
    tick_mon;
    check_eq("blk_wr_early", Tx_WR, 0);
    tick_mon;
    check_eq("blk_wr", Tx_WR, 1);
    check_eq("blk_data", Tx_DATA, 8'h5A);
    transmit(1, 3);
    check_eq("blk_ack_cnt", mon_ack_cnt, 1);

    // Reset in WAIT_DONE
    do_reset;
    clear_mon;
    req_data = 32'h0000_C300;
    req = 4'b0010;
    wait_wr("mid_wr");
    Tx_BUSY = 1'b1;
    repeat (3) tick_mon;
    check_eq("mid_ack_before", mon_ack_cnt, 1);
    check_eq("mid_busy_before", arb_busy, 1);
    reset = 1'b1;
    #1;
    check_eq("mid_ack", ack, 0);
    check_eq("mid_wr0", Tx_WR, 0);
    check_eq("mid_busy", arb_busy, 0);
    check_eq("mid_data", Tx_DATA, 0);
    check_eq("mid_grant", grant, 0);
    check_eq("mid_tmo", tx_timeout, 0);
    tick;
    tick;
    check_eq("mid_ack_hold", ack, 0);
    reset = 1'b0;
    Tx_BUSY = 1'b0;
    req_data = 32'hE700_0000;
    req = 4'b1000;
    clear_mon;
    wait_wr("mid_post_wr");
    check_eq("mid_post_grant", grant, 3);
    check_eq("mid_post_data", Tx_DATA, 8'hE7);
    transmit(1, 3);
    check_eq("mid_post_ack", mon_ack_or, 4'b1000);

    // Randomized run against the timeline model
    reset = 1'b1;
    req = 4'b0000;
    Tx_BUSY = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    req_hist[0] = 4'b0000;
    busy_hist[0] = 1'b0;
    last_m = 2'd3;
    ready = 0;
    in_xfer = 1'b0;
    waiting = 4'b0000;
    ack_due = -1;
    xfers = 0;
    win = 2'd0;
    exp_byte = 8'h00;
    for (int n = 1; n <= RN; n++) begin
      tick;
      exp_wr = 1'b0;
      if (!in_xfer && n >= 2 && (n - 2) >= ready && req_hist[n-2] != 4'b0000 && !busy_hist[n-2]) begin
        exp_wr = 1'b1;
        win = rr_model(req_hist[n-2], last_m);
        exp_byte = req_data[{win, 3'b000} +: 8];
        in_xfer = 1'b1;
        rise_at = n + int'($urandom_range(0, 3));
        hold = int'($urandom_range(2, 20));
        ack_due = rise_at + 1;
        waiting[win] = 1'b1;
        xfers++;
      end
      check_eq("rnd_wr", Tx_WR, exp_wr);
      if (in_xfer) begin
        check_eq("rnd_grant", grant, win);
        check_eq("rnd_data", Tx_DATA, exp_byte);
      end
      check_eq("rnd_ack", ack, (n == ack_due) ? (4'b0001 << win) : 4'b0000);
      check_eq("rnd_tmo", tx_timeout, 0);
      if (exp_wr && $urandom_range(0, 3) == 0) req[win] = 1'b0;
      if (n == ack_due) begin
        req[win] = 1'b0;
        waiting[win] = 1'b0;
      end
      if (in_xfer) begin
        if (n == rise_at + hold) begin
          Tx_BUSY = 1'b0;
          in_xfer = 1'b0;
          last_m = win;
          ready = n + 1;
        end else if (n >= rise_at) begin
          Tx_BUSY = 1'b1;
        end
      end
      if (n < RN - 60) begin
        for (int i = 0; i < 4; i++) begin
          if (!req[i] && !waiting[i] && $urandom_range(0, 3) == 0) begin
            req_data[{i[1:0], 3'b000} +: 8] = 8'($urandom);
            req[i] = 1'b1;
          end
        end
      end
      req_hist[n] = req;
      busy_hist[n] = Tx_BUSY;
    end
    check_eq("rnd_activity", (xfers > 20) ? 1 : 0, 1);

    // Transmitter never accepts
    do_reset;
    clear_mon;
    drop_on_ack = 1'b0;
    req_data = 32'h0000_003C;
    req = 4'b0001;
    wait_wr("tmo_wr");
    clear_mon;
`ifdef UART_TX_ARB_TIMEOUT_EN
    repeat (99) tick_mon;
    check_eq("tmo_early", mon_tmo_cnt, 0);
    tick_mon;
    check_eq("tmo_pulse", tx_timeout, 1);
    check_eq("tmo_idle", arb_busy, 0);
    check_eq("tmo_no_ack", mon_ack_cnt, 0);
    req = 4'b0000;
    tick_mon;
    check_eq("tmo_pulse_end", tx_timeout, 0);
`else
    repeat (10000) tick_mon;
    check_eq("hang_no_tmo", mon_tmo_cnt, 0);
    check_eq("hang_no_ack", mon_ack_cnt, 0);
    check_eq("hang_no_wr", mon_wr_cnt, 0);
    check_eq("hang_busy", arb_busy, 1);
    check_eq("hang_grant", grant, 0);
`endif
    drop_on_ack = 1'b1;
    do_reset;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
